// File: rtl/full_adder_8b.sv
// full_adder_8b: registered ripple-carry adder {cout,s} = a + b + cin with signed overflow and zero flags
// Ports: clk, rst (sync, active-high), in_valid, a, b, cin -> s, cout, ovf, zero, out_valid
// Define FULL_ADDER_8B_PIPE2_EN to split the carry chain into two pipeline stages (latency 2 instead of 1)
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module full_adder_8b #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ov;
    logic             v;
`ifdef FULL_ADDER_8B_PIPE2_EN
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;
    logic [LO:0]   lc;
    logic [LO-1:0] ls;
    logic [LO-1:0] s1_lo;
    logic          s1_c;
    logic [HI-1:0] s1_a;
    logic [HI-1:0] s1_b;
    logic          s1_v;
    logic [HI:0]   hc;
    logic [HI-1:0] hs;
    assign lc[0] = cin;
    for (genvar i = 0; i < LO; i++) begin : g_lo
        fa_cell u_cell (.a(a[i]), .b(b[i]), .ci(lc[i]), .s(ls[i]), .co(lc[i+1]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_lo <= '0;
            s1_c  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
        end else begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_lo <= ls;
                s1_c  <= lc[LO];
                s1_a  <= a[WIDTH-1:LO];
                s1_b  <= b[WIDTH-1:LO];
            end
        end
    end
    // high half resumes the chain from the registered low-half carry
    assign hc[0] = s1_c;
    for (genvar j = 0; j < HI; j++) begin : g_hi
        fa_cell u_cell (.a(s1_a[j]), .b(s1_b[j]), .ci(hc[j]), .s(hs[j]), .co(hc[j+1]));
    end
    assign sum = {hs, s1_lo};
    assign co  = hc[HI];
    assign ov  = hc[HI] ^ hc[HI-1];
    assign v   = s1_v;
`else
    logic [WIDTH:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_cell u_cell (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
    end
    assign co = c[WIDTH];
    assign ov = c[WIDTH] ^ c[WIDTH-1];
    assign v  = in_valid;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v;
            if (v) begin
                s    <= sum;
                cout <= co;
                ovf  <= ov;
                zero <= (sum == '0);
            end
        end
    end
endmodule

// File: tb/tb_full_adder_8b.sv
// tb_full_adder_8b: table-driven self-checking bench for full_adder_8b
module tb_full_adder_8b;
`ifdef FULL_ADDER_8B_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       out_valid;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] es;
        logic       ec;
        logic       eo;
        logic       ez;
    } vec_t;

    vec_t vt [10];
    vec_t st [3];

    full_adder_8b #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
    endtask

    initial begin
        vt[0] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        vt[1] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vt[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vt[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vt[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vt[8] = '{8'hC0, 8'h3F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[9] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        st[0] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        st[1] = '{8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b0, 1'b0};
        st[2] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

        // reset held for two cycles
        tick();
        tick();
        check("rst_s", s, 8'h00);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_zero", zero, 1);
        check("rst_valid", out_valid, 0);
        rst = 1'b0;
        tick();
        check("idle_valid", out_valid, 0);

        // single operations at the configured latency
        for (int k = 0; k < 10; k++) begin
            drive(vt[k].a, vt[k].b, vt[k].cin);
            tick();
            in_valid = 1'b0;
            repeat (LAT - 1) tick();
            check($sformatf("v%0d_valid", k), out_valid, 1);
            check($sformatf("v%0d_s", k), s, vt[k].es);
            check($sformatf("v%0d_cout", k), cout, vt[k].ec);
            check($sformatf("v%0d_ovf", k), ovf, vt[k].eo);
            check($sformatf("v%0d_zero", k), zero, vt[k].ez);
            tick();
            check($sformatf("v%0d_drop", k), out_valid, 0);
            check($sformatf("v%0d_hold", k), s, vt[k].es);
        end

        // back-to-back stream, then idle with held outputs
        for (int c = 0; c < 4 + LAT; c++) begin
            if (c < 3) drive(st[c].a, st[c].b, st[c].cin);
            else in_valid = 1'b0;
            tick();
            if (c - LAT + 1 >= 0 && c - LAT + 1 < 3) begin
                check($sformatf("st%0d_valid", c - LAT + 1), out_valid, 1);
                check($sformatf("st%0d_s", c - LAT + 1), s, st[c - LAT + 1].es);
                check($sformatf("st%0d_cout", c - LAT + 1), cout, st[c - LAT + 1].ec);
                check($sformatf("st%0d_zero", c - LAT + 1), zero, st[c - LAT + 1].ez);
            end else if (c - LAT + 1 >= 3) begin
                check("st_idle_valid", out_valid, 0);
                check("st_hold_s", s, 8'h00);
                check("st_hold_cout", cout, 1);
                check("st_hold_zero", zero, 1);
            end
        end

        // operation presented together with reset is discarded
        drive(8'h12, 8'h34, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        check("pre_s", s, 8'h46);
        rst = 1'b1;
        drive(8'h55, 8'h55, 1'b0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < LAT + 1; c++) begin
            check("rstop_valid", out_valid, 0);
            check("rstop_s", s, 8'h00);
            check("rstop_zero", zero, 1);
            tick();
        end

        // operation in flight when reset arrives is dropped
        drive(8'h21, 8'h43, 1'b0);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < LAT + 1; c++) begin
            check("flight_valid", out_valid, 0);
            check("flight_s", s, 8'h00);
            check("flight_cout", cout, 0);
            tick();
        end

        // first operation after reset uses the normal latency
        drive(8'h01, 8'h02, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        check("post_valid", out_valid, 1);
        check("post_s", s, 8'h03);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
